// File: rtl/fp_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake; shift-amount levels split LSB-first over PIPE_STAGES.
// Optional sticky output (OR of bits lost on right shifts) is built only when FP_SHIFTER_STICKY_EN is defined.
module fp_shifter_pipe #(
   parameter int DATA_WIDTH  = 24,
   parameter int SH_WIDTH    = 5,
   parameter int PIPE_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_tc,
   input  logic [SH_WIDTH-1:0]   sh,
   input  logic                  sh_tc,
   input  logic                  sh_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  sticky_out
);

   localparam int BASE  = SH_WIDTH / PIPE_STAGES;
   localparam int EXTRA = SH_WIDTH % PIPE_STAGES;

   // One barrel level: shift/rotate by amt, where amt is a power of two that may exceed the width.
   function automatic logic [DATA_WIDTH-1:0] levelShift(
      input logic [DATA_WIDTH-1:0] d,
      input logic                  right,
      input logic                  shiftMode,
      input logic                  fill,
      input int                    amt
   );
      logic [2*DATA_WIDTH-1:0] dbl;
      int r;
      levelShift = d;
      if (shiftMode) begin
         if (amt >= DATA_WIDTH)
            levelShift = {DATA_WIDTH{fill}};
         else if (right)
            levelShift = (d >> amt) | ({DATA_WIDTH{fill}} << (DATA_WIDTH - amt));
         else
            levelShift = d << amt;
      end else begin
         r = amt % DATA_WIDTH;
         dbl = right ? ({d, d} >> r) : ({d, d} << r);
         levelShift = right ? dbl[DATA_WIDTH-1:0] : dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   endfunction

`ifdef FP_SHIFTER_STICKY_EN
   function automatic logic lostBits(
      input logic [DATA_WIDTH-1:0] d,
      input logic                  right,
      input logic                  shiftMode,
      input int                    amt
   );
      logic [DATA_WIDTH-1:0] mask;
      lostBits = 1'b0;
      if (shiftMode && right) begin
         if (amt >= DATA_WIDTH) begin
            lostBits = |d;
         end else begin
            mask = ~({DATA_WIDTH{1'b1}} << amt);
            lostBits = |(d & mask);
         end
      end
   endfunction
`endif

   logic adv;
   logic decRight;
   logic decFill;
   logic [SH_WIDTH-1:0] decMag;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // A negative signed amount becomes a right shift by its magnitude; the most negative value wraps to 2^(SH_WIDTH-1).
   always_comb begin
      decRight = sh_tc & sh[SH_WIDTH-1];
      decMag   = decRight ? ((~sh) + SH_WIDTH'(1)) : sh;
      decFill  = sh_mode & decRight & data_tc & data_in[DATA_WIDTH-1];
   end

   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      localparam int CNT   = BASE + ((k < EXTRA) ? 1 : 0);
      localparam int START = k * BASE + ((k < EXTRA) ? k : EXTRA);
      localparam int NEXT  = START + CNT;

      logic                  srcValid;
      logic                  srcRight;
      logic                  srcMode;
      logic                  srcFill;
      logic [SH_WIDTH-1:START] srcMag;
      logic [DATA_WIDTH-1:0] srcData;
      logic [DATA_WIDTH-1:0] data_d;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] chain [CNT+1];
`ifdef FP_SHIFTER_STICKY_EN
      logic                  srcSticky;
      logic                  sticky_d;
      logic                  sticky_q;
      logic                  stickyChain [CNT+1];
`endif

      if (k == 0) begin : g_head
         assign srcValid = in_valid;
         assign srcData  = data_in;
         assign srcRight = decRight;
         assign srcMode  = sh_mode;
         assign srcFill  = decFill;
         assign srcMag   = decMag;
`ifdef FP_SHIFTER_STICKY_EN
         assign srcSticky = 1'b0;
`endif
      end else begin : g_link
         assign srcValid = g_stage[k-1].valid_q;
         assign srcData  = g_stage[k-1].data_q;
         assign srcRight = g_stage[k-1].g_carry.right_q;
         assign srcMode  = g_stage[k-1].g_carry.mode_q;
         assign srcFill  = g_stage[k-1].g_carry.fill_q;
         assign srcMag   = g_stage[k-1].g_carry.mag_q;
`ifdef FP_SHIFTER_STICKY_EN
         assign srcSticky = g_stage[k-1].sticky_q;
`endif
      end

      assign chain[0] = srcData;
`ifdef FP_SHIFTER_STICKY_EN
      assign stickyChain[0] = srcSticky;
`endif
      for (genvar i = 0; i < CNT; i++) begin : g_level
         assign chain[i+1] = srcMag[START+i]
                           ? levelShift(chain[i], srcRight, srcMode, srcFill, 1 << (START + i))
                           : chain[i];
`ifdef FP_SHIFTER_STICKY_EN
         assign stickyChain[i+1] = stickyChain[i]
                                 | (srcMag[START+i] & lostBits(chain[i], srcRight, srcMode, 1 << (START + i)));
`endif
      end
      assign data_d = chain[CNT];
`ifdef FP_SHIFTER_STICKY_EN
      assign sticky_d = stickyChain[CNT];
`endif

      // Whole pipe freezes when the output is held; reset drops every in-flight beat.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef FP_SHIFTER_STICKY_EN
            sticky_q <= 1'b0;
`endif
         end else if (adv) begin
            valid_q <= srcValid;
            data_q  <= data_d;
`ifdef FP_SHIFTER_STICKY_EN
            sticky_q <= sticky_d;
`endif
         end
      end

      // Control and the not-yet-applied amount bits ride along to the later stages.
      if (k < PIPE_STAGES - 1) begin : g_carry
         logic                   right_q;
         logic                   mode_q;
         logic                   fill_q;
         logic [SH_WIDTH-1:NEXT] mag_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               right_q <= 1'b0;
               mode_q  <= 1'b0;
               fill_q  <= 1'b0;
               mag_q   <= '0;
            end else if (adv) begin
               right_q <= srcRight;
               mode_q  <= srcMode;
               fill_q  <= srcFill;
               mag_q   <= srcMag[SH_WIDTH-1:NEXT];
            end
         end
      end
   end

   assign out_valid = g_stage[PIPE_STAGES-1].valid_q;
   assign data_out  = g_stage[PIPE_STAGES-1].data_q;
`ifdef FP_SHIFTER_STICKY_EN
   assign sticky_out = g_stage[PIPE_STAGES-1].sticky_q;
`else
   assign sticky_out = 1'b0;
`endif

endmodule
